// File: rtl/bram_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_sched_pkg : shared types for the BRAM access scheduler   (rev 1.0)
// ----------------------------------------------------------------------------
package bram_sched_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   typedef enum logic [0:0] {
      CLS_CPU = 1'b0,
      CLS_DMA = 1'b1
   } cls_e;

   typedef struct packed {
      logic valid;
      cls_e cls;
   } tag_t;

   localparam int STAT_W = 16;

endpackage
`default_nettype wire

// File: rtl/bram_sched_tag_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_sched_tag_pipe : RD_LAT-deep read tag pipe, steers Do to its requester (rev 1.0)
// ----------------------------------------------------------------------------
module bram_sched_tag_pipe
   import bram_sched_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rd_issue_i,
   input  logic rd_cls_i,
   output logic cpu_rsp_valid_o,
   output logic dma_rsp_valid_o,
   output logic pending_o
);

   tag_t pipe_q [RD_LAT];

   // Stage 0 captures the read visible on the BRAM port this cycle, so the
   // last stage lines up with Do exactly RD_LAT cycles later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= '{valid: rd_issue_i, cls: cls_e'(rd_cls_i)};
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   always_comb begin
      pending_o = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         pending_o = pending_o | pipe_q[i].valid;
      end
   end

   assign cpu_rsp_valid_o = pipe_q[RD_LAT-1].valid && (pipe_q[RD_LAT-1].cls == CLS_CPU);
   assign dma_rsp_valid_o = pipe_q[RD_LAT-1].valid && (pipe_q[RD_LAT-1].cls == CLS_DMA);

endmodule
`default_nettype wire

// File: rtl/bram_access_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_access_scheduler : CPU refill bursts / DMA reads+writes onto one BRAM port;
// optional counters with BRAM_SCHED_STATS_EN                              (rev 1.0)
// ----------------------------------------------------------------------------
module bram_access_scheduler
   import bram_sched_pkg::*;
#(
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 8,
   parameter int RD_LAT    = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cpu_miss_valid,
   input  logic [ADDR_W-1:0] cpu_miss_addr,
   output logic              cpu_miss_ready,
   output logic              cpu_rsp_valid,
   input  logic              dma_r_valid,
   input  logic [ADDR_W-1:0] dma_r_addr,
   output logic              dma_r_ready,
   input  logic              dma_w_valid,
   input  logic [ADDR_W-1:0] dma_w_addr,
   input  logic [DATA_W-1:0] dma_w_data,
   output logic              dma_w_ready,
   output logic              dma_rsp_valid,
   output logic              bram_in_valid,
   output logic              bram_wr,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_di,
   output logic              busy
`ifdef BRAM_SCHED_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_cpu_bursts,
   output logic [STAT_W-1:0] stat_dma_reads,
   output logic [STAT_W-1:0] stat_dma_writes
`endif
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   cls_e                last_cls_q, last_cls_d;
   cls_e                cls_q, cls_d;
   logic                in_valid_q, in_valid_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   di_q, di_d;

   logic last_beat_w, can_accept_w, dma_req_w, grant_cpu_w, grant_dma_w;
   logic tag_pending_w;

   assign last_beat_w  = (beat_q == BEAT_W'(BURST_LEN - 1));
   assign can_accept_w = (state_q == IDLE) || last_beat_w;
   assign dma_req_w    = dma_r_valid || dma_w_valid;
   // On conflict the class that did not win last time gets the port.
   assign grant_cpu_w  = cpu_miss_valid && (!dma_req_w || (last_cls_q == CLS_DMA));
   assign grant_dma_w  = dma_req_w && !grant_cpu_w;

   assign cpu_miss_ready = !wb_rst_i && can_accept_w && grant_cpu_w;
   assign dma_w_ready    = !wb_rst_i && can_accept_w && grant_dma_w && dma_w_valid;
   assign dma_r_ready    = !wb_rst_i && can_accept_w && grant_dma_w && !dma_w_valid && dma_r_valid;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      base_d     = base_q;
      last_cls_d = last_cls_q;
      cls_d      = cls_q;
      in_valid_d = 1'b0;
      wr_d       = 1'b0;
      addr_d     = addr_q;
      di_d       = di_q;

      if (state_q == BURST) begin
         if (last_beat_w) begin
            state_d = IDLE;
         end else begin
            beat_d     = beat_q + BEAT_W'(1);
            in_valid_d = 1'b1;
            addr_d     = base_q + ADDR_W'(beat_q) + ADDR_W'(1);
            cls_d      = CLS_CPU;
         end
      end

      // Acceptance on the last burst beat overrides the return to IDLE.
      if (cpu_miss_ready) begin
         state_d    = BURST;
         beat_d     = '0;
         base_d     = cpu_miss_addr;
         in_valid_d = 1'b1;
         addr_d     = cpu_miss_addr;
         cls_d      = CLS_CPU;
         last_cls_d = CLS_CPU;
      end else if (dma_w_ready) begin
         in_valid_d = 1'b1;
         wr_d       = 1'b1;
         addr_d     = dma_w_addr;
         di_d       = dma_w_data;
         cls_d      = CLS_DMA;
         last_cls_d = CLS_DMA;
      end else if (dma_r_ready) begin
         in_valid_d = 1'b1;
         addr_d     = dma_r_addr;
         cls_d      = CLS_DMA;
         last_cls_d = CLS_DMA;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         base_q     <= '0;
         last_cls_q <= CLS_DMA;
         cls_q      <= CLS_CPU;
         in_valid_q <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         di_q       <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         base_q     <= base_d;
         last_cls_q <= last_cls_d;
         cls_q      <= cls_d;
         in_valid_q <= in_valid_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         di_q       <= di_d;
      end
   end

   bram_sched_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk_i           (wb_clk_i),
      .rst_i           (wb_rst_i),
      .rd_issue_i      (in_valid_q && !wr_q),
      .rd_cls_i        (cls_q == CLS_DMA),
      .cpu_rsp_valid_o (cpu_rsp_valid),
      .dma_rsp_valid_o (dma_rsp_valid),
      .pending_o       (tag_pending_w)
   );

   assign bram_in_valid = in_valid_q;
   assign bram_wr       = wr_q;
   assign bram_addr     = addr_q;
   assign bram_di       = di_q;
   assign busy          = (state_q == BURST) || (in_valid_q && !wr_q) || tag_pending_w;

`ifdef BRAM_SCHED_STATS_EN
   logic [STAT_W-1:0] stat_cpu_q, stat_rd_q, stat_wr_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         stat_cpu_q <= '0;
         stat_rd_q  <= '0;
         stat_wr_q  <= '0;
      end else begin
         if (cpu_miss_ready && (stat_cpu_q != '1)) stat_cpu_q <= stat_cpu_q + STAT_W'(1);
         if (dma_r_ready    && (stat_rd_q  != '1)) stat_rd_q  <= stat_rd_q  + STAT_W'(1);
         if (dma_w_ready    && (stat_wr_q  != '1)) stat_wr_q  <= stat_wr_q  + STAT_W'(1);
      end
   end

   assign stat_cpu_bursts = stat_cpu_q;
   assign stat_dma_reads  = stat_rd_q;
   assign stat_dma_writes = stat_wr_q;
`endif

endmodule
`default_nettype wire
